// File: rtl/axi_addr_slice_pkg.sv
// Shared types and constants for the AXI address-channel register slice.
package axi_addr_slice_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axi_addr_skid.sv
// Single-channel two-entry skid buffer (main + skid) with registered valid/ready.
// Optional m-handshake counter enabled by AXI_ADDR_SLICE_STATS_EN.
module axi_addr_skid
  import axi_addr_slice_pkg::*;
#(
  parameter int unsigned DATA_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef AXI_ADDR_SLICE_STATS_EN
  ,
  output logic [CNT_W-1:0]  xfer_cnt
`endif
);

  skid_state_e       state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              s_hs;
  logic              m_hs;

  assign s_hs = s_valid & s_ready_q;
  assign m_hs = m_valid_q & m_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (s_hs) state_d = ST_ONE;
      end
      ST_ONE: begin
        if (s_hs && !m_hs)      state_d = ST_FULL;
        else if (!s_hs && m_hs) state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (m_hs) state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output and datapath next values; ready/valid follow the next state
  always_comb begin
    s_ready_d = (state_d != ST_FULL);
    m_valid_d = (state_d != ST_EMPTY);
    main_d    = main_q;
    skid_d    = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (s_hs) main_d = s_data;
      end
      ST_ONE: begin
        if (s_hs && m_hs) main_d = s_data;
        else if (s_hs)    skid_d = s_data;
      end
      ST_FULL: begin
        if (m_hs) begin
          main_d = skid_q;
          skid_d = '0;
        end
      end
      default: begin
        main_d = '0;
        skid_d = '0;
      end
    endcase
  end

  // Registered outputs and payload storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

`ifdef AXI_ADDR_SLICE_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Downstream transfer counter, wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (m_hs) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: rtl/axi_addr_slice.sv
// AXI AW/AR address register slice: two independent skid-buffer channels.
// Optional per-channel transfer counters enabled by AXI_ADDR_SLICE_STATS_EN.
module axi_addr_slice
  import axi_addr_slice_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready
`ifdef AXI_ADDR_SLICE_STATS_EN
  ,
  output logic [CNT_W-1:0]  aw_xfer_cnt,
  output logic [CNT_W-1:0]  ar_xfer_cnt
`endif
);

  axi_addr_skid #(
    .DATA_W (ADDR_W)
  ) u_aw_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_axi_awaddr),
    .s_valid  (s_axi_awvalid),
    .s_ready  (s_axi_awready),
    .m_data   (m_axi_awaddr),
    .m_valid  (m_axi_awvalid),
    .m_ready  (m_axi_awready)
`ifdef AXI_ADDR_SLICE_STATS_EN
    ,
    .xfer_cnt (aw_xfer_cnt)
`endif
  );

  axi_addr_skid #(
    .DATA_W (ADDR_W)
  ) u_ar_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_axi_araddr),
    .s_valid  (s_axi_arvalid),
    .s_ready  (s_axi_arready),
    .m_data   (m_axi_araddr),
    .m_valid  (m_axi_arvalid),
    .m_ready  (m_axi_arready)
`ifdef AXI_ADDR_SLICE_STATS_EN
    ,
    .xfer_cnt (ar_xfer_cnt)
`endif
  );

endmodule

// File: tb/tb_axi_addr_slice.sv
// Self-checking bench for axi_addr_slice: queue-based reference model per channel.
module tb_axi_addr_slice;

  logic        clk;
  logic        rst_n;
  logic        s_valid [2];
  logic [31:0] s_addr  [2];
  logic        m_ready [2];
  logic        obs_mvalid [2];
  logic        obs_sready [2];
  logic [31:0] obs_maddr  [2];
`ifdef AXI_ADDR_SLICE_STATS_EN
  logic [31:0] obs_cnt [2];
  logic [31:0] exp_cnt [2];
`endif

  logic [31:0] aw_q [$];
  logic [31:0] ar_q [$];
  logic        exp_sready [2];
  logic        s_hs_m [2];
  logic        m_hs_m [2];
  int          pops [2];
  int          total;
  int          bad;

  axi_addr_slice dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (s_addr[0]),
    .s_axi_awvalid (s_valid[0]),
    .s_axi_awready (obs_sready[0]),
    .s_axi_araddr  (s_addr[1]),
    .s_axi_arvalid (s_valid[1]),
    .s_axi_arready (obs_sready[1]),
    .m_axi_awaddr  (obs_maddr[0]),
    .m_axi_awvalid (obs_mvalid[0]),
    .m_axi_awready (m_ready[0]),
    .m_axi_araddr  (obs_maddr[1]),
    .m_axi_arvalid (obs_mvalid[1]),
    .m_axi_arready (m_ready[1])
`ifdef AXI_ADDR_SLICE_STATS_EN
    ,
    .aw_xfer_cnt   (obs_cnt[0]),
    .ar_xfer_cnt   (obs_cnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string cname(input int c);
    return (c == 0) ? "aw" : "ar";
  endfunction

  function automatic int qsize(input int c);
    return (c == 0) ? aw_q.size() : ar_q.size();
  endfunction

  function automatic logic [31:0] qfront(input int c);
    return (c == 0) ? aw_q[0] : ar_q[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aw_q.delete();
    ar_q.delete();
    for (int c = 0; c < 2; c++) begin
      exp_sready[c] = 1'b0;
      s_hs_m[c]     = 1'b0;
      m_hs_m[c]     = 1'b0;
`ifdef AXI_ADDR_SLICE_STATS_EN
      exp_cnt[c]    = 32'd0;
`endif
    end
  endtask

  // Check outputs mid-cycle, then advance one edge and update the model
  task automatic tick();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk({cname(c), "_m_valid"}, 32'(obs_mvalid[c]), 32'(qsize(c) > 0));
      chk({cname(c), "_s_ready"}, 32'(obs_sready[c]), 32'(exp_sready[c]));
      if (qsize(c) > 0) chk({cname(c), "_m_addr"}, obs_maddr[c], qfront(c));
`ifdef AXI_ADDR_SLICE_STATS_EN
      chk({cname(c), "_xfer_cnt"}, obs_cnt[c], exp_cnt[c]);
`endif
      s_hs_m[c] = s_valid[c] & exp_sready[c];
      m_hs_m[c] = m_ready[c] & (qsize(c) > 0);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_hs_m[c]) begin
          if (c == 0) void'(aw_q.pop_front());
          else        void'(ar_q.pop_front());
          pops[c]++;
`ifdef AXI_ADDR_SLICE_STATS_EN
          exp_cnt[c] = exp_cnt[c] + 32'd1;
`endif
        end
        if (s_hs_m[c]) begin
          if (c == 0) aw_q.push_back(s_addr[c]);
          else        ar_q.push_back(s_addr[c]);
        end
        exp_sready[c] = (qsize(c) < 2);
      end
    end
  endtask

  // Present one address on a channel until accepted, bounded
  task automatic send_one(input int c, input logic [31:0] addr);
    bit done;
    done = 1'b0;
    s_valid[c] = 1'b1;
    s_addr[c]  = addr;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      done = s_hs_m[c];
    end
    if (!done) chk({cname(c), "_send_timeout"}, 32'd0, 32'd1);
    s_valid[c] = 1'b0;
  endtask

  initial begin
    int p0;
    bit done;
    total = 0;
    bad   = 0;
    pops[0] = 0;
    pops[1] = 0;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      s_valid[c] = 1'b0;
      s_addr[c]  = 32'd0;
      m_ready[c] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk({cname(c), "_rst_m_valid"}, 32'(obs_mvalid[c]), 32'd0);
      chk({cname(c), "_rst_s_ready"}, 32'(obs_sready[c]), 32'd0);
      chk({cname(c), "_rst_m_addr"}, obs_maddr[c], 32'd0);
    end

    // Reset release with AW request waiting
    rst_n      = 1'b1;
    s_valid[0] = 1'b1;
    s_addr[0]  = 32'h0000_1000;
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    tick();
    chk("aw_ready_after_release", 32'(obs_sready[0]), 32'd1);
    tick();
    s_valid[0] = 1'b0;
    chk("aw_first_valid", 32'(obs_mvalid[0]), 32'd1);
    chk("aw_first_addr", obs_maddr[0], 32'h0000_1000);
    tick();
    tick();

    // Back-to-back AR stream at full throughput
    p0 = pops[1];
    for (int i = 0; i < 8; i++) begin
      s_valid[1] = 1'b1;
      s_addr[1]  = 32'(i * 4);
      tick();
      chk("ar_stream_accept", 32'(s_hs_m[1]), 32'd1);
    end
    s_valid[1] = 1'b0;
    tick();
    tick();
    chk("ar_stream_count", 32'(pops[1] - p0), 32'd8);

    // AW backpressure: two accepted, third held
    m_ready[0] = 1'b0;
    p0 = pops[0];
    send_one(0, 32'h0000_000A);
    send_one(0, 32'h0000_000B);
    s_valid[0] = 1'b1;
    s_addr[0]  = 32'h0000_000C;
    repeat (3) tick();
    chk("aw_bp_ready_low", 32'(obs_sready[0]), 32'd0);
    chk("aw_bp_head", obs_maddr[0], 32'h0000_000A);
    m_ready[0] = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = s_hs_m[0];
    end
    if (!done) chk("aw_bp_c_timeout", 32'd0, 32'd1);
    s_valid[0] = 1'b0;
    repeat (4) tick();
    chk("aw_bp_count", 32'(pops[0] - p0), 32'd3);

    // Reset while FULL discards both entries at once
    m_ready[0] = 1'b0;
    send_one(0, 32'hDEAD_0001);
    send_one(0, 32'hDEAD_0002);
    tick();
    chk("aw_full_before_rst", 32'(obs_sready[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("aw_rst_async_valid", 32'(obs_mvalid[0]), 32'd0);
    chk("aw_rst_async_ready", 32'(obs_sready[0]), 32'd0);
    model_reset();
    tick();
    tick();
    rst_n      = 1'b1;
    m_ready[0] = 1'b1;
    repeat (5) tick();

    // Randomised independent traffic on both channels
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!(s_valid[c] && !s_hs_m[c])) begin
          s_valid[c] = 1'($urandom_range(0, 1));
          s_addr[c]  = $urandom;
        end
      end
      m_ready[0] = ($urandom_range(0, 9) < 3);
      m_ready[1] = ($urandom_range(0, 9) < 8);
      tick();
    end
    s_valid[0] = 1'b0;
    s_valid[1] = 1'b0;
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    repeat (4) tick();
    chk("aw_drained", 32'(qsize(0)), 32'd0);
    chk("ar_drained", 32'(qsize(1)), 32'd0);

`ifdef AXI_ADDR_SLICE_STATS_EN
    // Counter wrap from all-ones
    force dut.u_aw_skid.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_aw_skid.cnt_q;
    exp_cnt[0] = 32'hFFFF_FFFF;
    send_one(0, 32'h0000_5000);
    tick();
    tick();
    chk("aw_cnt_wrap", obs_cnt[0], 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_addr_slice.md
# axi_addr_slice

Registered pipeline stage for the AXI write-address (AW) and read-address (AR) channels. It sits directly downstream of a master's address ports and upstream of the interconnect. It breaks the combinational VALID/READY and payload paths in both directions with a two-entry skid buffer per channel, and sustains full throughput (one transfer per cycle per channel). Payload is passed through unmodified and in order.

## Interface
Parameters:
- ADDR_W, 32, address width of both channels
- The skid entry count is fixed at 2 (main + skid) and is not a parameter.

Ports:
- Clocking and reset are fixed: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  input  1  sole clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- s_axi_awaddr  input  ADDR_W  upstream AW address
- s_axi_awvalid  input  1  upstream AW valid
- s_axi_awready  output  1  AW accept, registered
- s_axi_araddr  input  ADDR_W  upstream AR address
- s_axi_arvalid  input  1  upstream AR valid
- s_axi_arready  output  1  AR accept, registered
- m_axi_awaddr  output  ADDR_W  downstream AW address, registered
- m_axi_awvalid  output  1  downstream AW valid, registered
- m_axi_awready  input  1  downstream AW accept
- m_axi_araddr, m_axi_arvalid, m_axi_arready: as AW, for the AR channel

## Operation
- AW and AR are fully independent instances of the same channel logic. There is no cross-channel ordering or arbitration.
- Per-channel states:
  - EMPTY: no entries held.
  - ONE: main register valid.
  - FULL: main and skid both valid.
- Events: s-handshake = s_valid & s_ready; m-handshake = m_valid & m_ready.
- Transitions:
  - EMPTY: s-handshake → ONE. The payload loads into main.
  - ONE:
    - s-handshake only → FULL. The payload loads into skid.
    - m-handshake only → EMPTY.
    - Both at once → stays ONE. Main is reloaded from s.
  - FULL: m-handshake → ONE. Main takes skid; skid is cleared. s_ready is low in FULL, so no s-handshake is possible there.
- s_ready is a flop, not combinational. Its next value is high unless the next state is FULL.
- m_valid is high exactly in ONE and FULL. m_addr always shows main.
- Ordering: strictly FIFO. Skid is never presented before main.
- Holding a payload stable while s_valid is high and s_ready is low is the upstream's responsibility. The slice does not check it.
- Reset asserted mid-operation: all held entries are discarded and the state returns to EMPTY immediately (asynchronous).

## Timing
- Reset values: m_axi_awvalid = m_axi_arvalid = 0; s_axi_awready = s_axi_arready = 0; m_axi_awaddr = m_axi_araddr = 0.
- s_ready rises on the first clk edge after rst_n deasserts.
- Latency: an s-handshake at edge N gives m_valid high after edge N, visible in cycle N+1.
- Throughput: with m_ready held high, one transfer per clock continuously. The channel never reaches FULL in this case.
- Backpressure: with m_ready low, two transfers are accepted, then s_ready is low from the cycle after the second accept.
- Release: the first m-handshake from FULL raises s_ready in the next cycle.
- No combinational path exists from any input to any output.

## Configuration
- AXI_ADDR_SLICE_STATS_EN defined:
  - Adds outputs aw_xfer_cnt and ar_xfer_cnt, each an output of width 32.
  - Each counts m-handshakes on its channel, wrapping modulo 2^32 (0xFFFFFFFF → 0).
  - Both reset to 0.
  - A counter updates in the cycle after the handshake.
- Undefined: these ports and the counters do not exist. Slice behaviour is otherwise identical.

## Structure
- Shared package axi_addr_slice_pkg holds:
  - the channel state enum (EMPTY/ONE/FULL, 2-bit encoding)
  - the default address-width constant
  - the counter width constant (32)
- One sub-module, axi_addr_skid: a single-channel skid buffer, parameterised by payload width, including the optional counter. The top level instantiates it twice (AW, AR).

## Test plan
- Reset release, s_awvalid=1, addr 0x1000, m_awready=1 → s_awready=1 one cycle after reset release; m_awaddr=0x1000 with m_awvalid=1 in the cycle after accept.
- Stream of 8 AR addresses 0x0..0x1C with m_arready held 1 → 8 outputs on 8 consecutive cycles, in order, s_arready never low.
- m_awready=0, send 0xA, 0xB, 0xC → 0xA and 0xB accepted, s_awready low while 0xC is held. Then m_awready=1 → outputs 0xA, 0xB, 0xC in order, no loss or duplication.
- Random valid/ready on both channels for 10k cycles → scoreboard order and content match per channel; AW stalls never affect AR.
- Reset asserted while FULL → m_valid=0 and s_ready=0 immediately; after release, no stale address is emitted.
- With AXI_ADDR_SLICE_STATS_EN, preload via 2^32−1 handshakes (force) plus 1 more → aw_xfer_cnt wraps to 0.
